// File: rtl/fan_pkg.sv
// fan_pkg: shared definitions for the fan subsystem.
//   - fan_state_e : measurement scheduler FSM states
//   - default clock / window / scale constants
//   - SLOT_W      : width of one packed RPM result slot
//   - sat_rpm()   : pulse count -> RPM, saturated to the slot width
package fan_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_SETTLE,
    ST_MEASURE,
    ST_STORE
  } fan_state_e;

  localparam int unsigned CLK_HZ            = 50_000_000;
  localparam int unsigned PULSES_PER_REV    = 2;
  localparam int unsigned DEF_WINDOW_CYCLES = 50_000_000;
  localparam int unsigned DEF_SETTLE_CYCLES = 1024;
  // RPM per counted pulse = 60 * f_clk / (window * pulses_per_rev)
  localparam int unsigned DEF_RPM_SCALE =
    int'((64'd60 * CLK_HZ) / (64'(DEF_WINDOW_CYCLES) * PULSES_PER_REV));
  localparam int unsigned SLOT_W = 16;

  // 16x16 product always fits in 32 bits; clamp to the slot width.
  function automatic logic [SLOT_W-1:0] sat_rpm(input logic [15:0] pulses,
                                                input logic [15:0] scale);
    logic [31:0] prod;
    prod = 32'(pulses) * 32'(scale);
    return (|prod[31:16]) ? 16'hFFFF : prod[15:0];
  endfunction

endpackage

// File: rtl/fan_tach_sync.sv
// fan_tach_sync: W-bit two-flop synchronizer for raw asynchronous TACH pins.
//   clk     : destination clock
//   rstn    : async active-low reset (outputs clear to 0)
//   async_i : raw asynchronous inputs
//   sync_o  : inputs synchronized to clk (2-cycle latency)
module fan_tach_sync #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [W-1:0] async_i,
  output logic [W-1:0] sync_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/fan_tach_scheduler.sv
// fan_tach_scheduler: round-robin TACH measurement over N_FANS inputs with
// one shared pulse counter and RPM scaler.
//   clk, rstn  : clock, async active-low reset
//   tach       : raw asynchronous TACH pins
//   enable     : scan enable (level); dropping it aborts the current fan
//   fan_mask   : fans included in the scan, sampled at each channel select
//   stall_clr  : per-fan clear of the sticky stall flag (a set wins)
//   rpm_all    : packed 16-bit RPM per fan, fan i at [16i+15:16i]
//   rpm_valid  : one-cycle pulse when fan i's slot updates
//   stall      : sticky, fan measured zero pulses over a full window
//   scan_done  : one-cycle pulse when the highest enabled fan is stored
//   busy       : FSM not in IDLE
module fan_tach_scheduler
  import fan_pkg::*;
#(
  parameter int N_FANS        = 4,
  parameter int WINDOW_CYCLES = DEF_WINDOW_CYCLES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int RPM_SCALE     = DEF_RPM_SCALE
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [N_FANS-1:0]          tach,
  input  logic                       enable,
  input  logic [N_FANS-1:0]          fan_mask,
  input  logic [N_FANS-1:0]          stall_clr,
  output logic [SLOT_W*N_FANS-1:0]   rpm_all,
  output logic [N_FANS-1:0]          rpm_valid,
  output logic [N_FANS-1:0]          stall,
  output logic                       scan_done,
  output logic                       busy
);

  localparam int CH_W = (N_FANS > 1) ? $clog2(N_FANS) : 1;

  fan_state_e state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d;        // channel being measured
  logic [CH_W-1:0]   last_q, last_d;    // last channel actually stored
  logic [N_FANS-1:0] mask_q, mask_d;    // mask captured at SELECT
  logic [31:0]       cnt_q, cnt_d;      // settle / window cycle counter
  logic [15:0]       pulses_q, pulses_d;
  logic              prev_q, prev_d;    // edge-history bit
  logic              store;

  logic [N_FANS-1:0][SLOT_W-1:0] rpm_q;
  logic [N_FANS-1:0] rpm_valid_q, stall_q;
  logic              scan_done_q;

  logic [N_FANS-1:0] tach_s;
  logic              cur;
  logic              nxt_found;
  logic [CH_W-1:0]   nxt_ch, hi_ch, cand;

  fan_tach_sync #(.W(N_FANS)) u_sync (
    .clk     (clk),
    .rstn    (rstn),
    .async_i (tach),
    .sync_o  (tach_s)
  );

  assign cur = tach_s[ch_q];

  // Next set mask bit strictly after the last stored channel, wrapping.
  // last_q only moves on STORE, so an aborted channel is retried.
  always_comb begin
    nxt_found = 1'b0;
    nxt_ch    = '0;
    cand      = '0;
    for (int k = 1; k <= N_FANS; k++) begin
      cand = CH_W'((int'(last_q) + k) % N_FANS);
      if (!nxt_found && fan_mask[cand]) begin
        nxt_found = 1'b1;
        nxt_ch    = cand;
      end
    end
  end

  always_comb begin
    hi_ch = '0;
    for (int i = 0; i < N_FANS; i++)
      if (mask_q[i]) hi_ch = CH_W'(i);
  end

  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    last_d   = last_q;
    mask_d   = mask_q;
    cnt_d    = cnt_q;
    pulses_d = pulses_q;
    prev_d   = prev_q;
    store    = 1'b0;
    case (state_q)
      ST_IDLE:
        if (enable && |fan_mask) state_d = ST_SELECT;
      ST_SELECT:
        if (!enable || !nxt_found) state_d = ST_IDLE;
        else begin
          ch_d     = nxt_ch;
          mask_d   = fan_mask;
          cnt_d    = '0;
          pulses_d = '0;
          state_d  = ST_SETTLE;
        end
      ST_SETTLE:
        if (!enable) state_d = ST_IDLE;
        else if (cnt_q == 32'(SETTLE_CYCLES - 1)) begin
          cnt_d   = '0;
          prev_d  = cur;
          state_d = ST_MEASURE;
        end else cnt_d = cnt_q + 32'd1;
      ST_MEASURE:
        if (!enable) state_d = ST_IDLE;
        else begin
          prev_d = cur;
          if (prev_q && !cur && pulses_q != 16'hFFFF) pulses_d = pulses_q + 16'd1;
          if (cnt_q == 32'(WINDOW_CYCLES - 1)) state_d = ST_STORE;
          else cnt_d = cnt_q + 32'd1;
        end
      ST_STORE: begin
        store   = 1'b1;
        last_d  = ch_q;
        state_d = (enable && |fan_mask) ? ST_SELECT : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      ch_q     <= '0;
      last_q   <= CH_W'(N_FANS - 1);
      mask_q   <= '0;
      cnt_q    <= '0;
      pulses_q <= '0;
      prev_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      last_q   <= last_d;
      mask_q   <= mask_d;
      cnt_q    <= cnt_d;
      pulses_q <= pulses_d;
      prev_q   <= prev_d;
    end
  end

  // Result registers; the stall set is written after the clear so it wins.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rpm_q       <= '0;
      rpm_valid_q <= '0;
      stall_q     <= '0;
      scan_done_q <= 1'b0;
    end else begin
      rpm_valid_q <= '0;
      scan_done_q <= 1'b0;
      stall_q     <= stall_q & ~stall_clr;
      if (store) begin
        rpm_q[ch_q]       <= sat_rpm(pulses_q, 16'(RPM_SCALE));
        rpm_valid_q[ch_q] <= 1'b1;
        if (pulses_q == 16'd0) stall_q[ch_q] <= 1'b1;
        scan_done_q       <= (ch_q == hi_ch);
      end
    end
  end

  assign rpm_all   = rpm_q;
  assign rpm_valid = rpm_valid_q;
  assign stall     = stall_q;
  assign scan_done = scan_done_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fan_tach_scheduler.sv
// Bench for fan_tach_scheduler. TACH pins are periodic waveforms whose period
// divides the window, so each fan's pulse count is window/period regardless of
// phase (0 for a stuck pin). A second instance with RPM_SCALE=200 shares all
// inputs to cover result saturation.
module tb_fan_tach_scheduler;
  localparam int N       = 4;
  localparam int WIN     = 1000;
  localparam int SET     = 16;
  localparam int PER_FAN = WIN + SET + 2;

  logic        clk = 1'b0, rstn = 1'b0, enable = 1'b0;
  logic [3:0]  tach = '0, fan_mask = '0, stall_clr = '0;
  logic [63:0] rpm_all, rpm_all2;
  logic [3:0]  rpm_valid, rpm_valid2, stall, stall2;
  logic        scan_done, scan_done2, busy, busy2;

  always #5 clk = ~clk;

  fan_tach_scheduler #(.N_FANS(N), .WINDOW_CYCLES(WIN), .SETTLE_CYCLES(SET),
                       .RPM_SCALE(30)) dut (
    .clk(clk), .rstn(rstn), .tach(tach), .enable(enable), .fan_mask(fan_mask),
    .stall_clr(stall_clr), .rpm_all(rpm_all), .rpm_valid(rpm_valid),
    .stall(stall), .scan_done(scan_done), .busy(busy));

  fan_tach_scheduler #(.N_FANS(N), .WINDOW_CYCLES(WIN), .SETTLE_CYCLES(SET),
                       .RPM_SCALE(200)) dut2 (
    .clk(clk), .rstn(rstn), .tach(tach), .enable(enable), .fan_mask(fan_mask),
    .stall_clr(stall_clr), .rpm_all(rpm_all2), .rpm_valid(rpm_valid2),
    .stall(stall2), .scan_done(scan_done2), .busy(busy2));

  // waveform description per fan: period 0 = stuck at lvl
  int       per[N], hi[N], ph[N];
  bit [3:0] lvl;
  int       cyc = 0;

  int n_cmp = 0, n_bad = 0;

  typedef struct { int fan; int pulses; bit done; } exp_t;
  exp_t     q[$];
  exp_t     e;
  int       m_rpm[N], m_rpm2[N];
  bit [3:0] m_stall;
  int       mlast = N - 1;
  int       pops = 0;
  longint   done_t[$];
  int       divs[12] = '{2, 4, 8, 10, 20, 40, 50, 100, 200, 250, 500, 1000};

  function automatic int rpm_of(int p, int s);
    longint v = longint'(p) * s;
    return (v > 65535) ? 65535 : int'(v);
  endfunction

  function automatic int pulses_of(int f);
    return (per[f] == 0) ? 0 : WIN / per[f];
  endfunction

  function automatic int hibit(logic [3:0] m);
    int h = 0;
    for (int i = 0; i < N; i++) if (m[i]) h = i;
    return h;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic set_fan(int f, int p, int h, int phs, bit l);
    per[f] = p; hi[f] = h; ph[f] = phs; lvl[f] = l;
  endtask

  // TACH pattern generator, driven away from the active edge
  initial forever begin
    @(negedge clk);
    cyc++;
    for (int i = 0; i < N; i++)
      tach[i] = (per[i] == 0) ? lvl[i] : (((cyc + ph[i]) % per[i]) < hi[i]);
  end

  // Monitor: every result pulse pops one expectation and checks the whole
  // output state against the reference model.
  initial forever begin
    @(negedge clk);
    if (rstn && (rpm_valid != 0 || scan_done || rpm_valid2 != 0)) begin
      if (q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_result: rpm_valid=%b scan_done=%b, nothing expected",
                 rpm_valid, scan_done);
      end else begin
        logic [63:0] ev, ev2;
        e = q.pop_front();
        m_rpm[e.fan]  = rpm_of(e.pulses, 30);
        m_rpm2[e.fan] = rpm_of(e.pulses, 200);
        if (e.pulses == 0) m_stall[e.fan] = 1'b1;
        for (int i = 0; i < N; i++) begin
          ev[16*i +: 16]  = 16'(m_rpm[i]);
          ev2[16*i +: 16] = 16'(m_rpm2[i]);
        end
        chk("rpm_valid",      64'(rpm_valid),  64'(4'b1 << e.fan));
        chk("rpm_valid_s200", 64'(rpm_valid2), 64'(4'b1 << e.fan));
        chk("scan_done",      64'(scan_done),  64'(e.done));
        chk("rpm_all",        rpm_all,         ev);
        chk("rpm_all_s200",   rpm_all2,        ev2);
        chk("stall",          64'(stall),      64'(m_stall));
        if (scan_done) done_t.push_back($time);
        pops++;
      end
    end
  end

  // Enable a scan with mask m until k results are stored, then stop.
  task automatic run_round(logic [3:0] m, int k);
    int f, tgt, c;
    bit found;
    fan_mask = m;
    f = mlast;
    for (int j = 0; j < k; j++) begin
      found = 1'b0;
      for (int s = 1; s <= N; s++)
        if (!found && m[(f + s) % N]) begin found = 1'b1; f = (f + s) % N; end
      q.push_back('{f, pulses_of(f), (f == hibit(m))});
    end
    mlast = f;
    tgt = pops + k;
    enable = 1'b1;
    @(negedge clk);
    chk("busy_rise", 64'(busy), 64'd1);
    c = 0;
    while (pops < tgt && c < k * PER_FAN + 50) begin @(negedge clk); c++; end
    chk("round_complete", 64'(pops), 64'(tgt));
    if (pops < tgt) q.delete();
    enable = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_after_round", 64'(busy), 64'd0);
  endtask

  initial begin
    #(1_500_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int tgt, c;
    logic [3:0] clr;
    for (int i = 0; i < N; i++) begin set_fan(i, 0, 0, 0, 1'b0); m_rpm[i] = 0; m_rpm2[i] = 0; end
    m_stall = '0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_rpm_all",   rpm_all,          64'd0);
    chk("rst_rpm_valid", 64'(rpm_valid),   64'd0);
    chk("rst_stall",     64'(stall),       64'd0);
    chk("rst_scan_done", 64'(scan_done),   64'd0);
    chk("rst_busy",      64'(busy),        64'd0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // single fan, back-to-back rounds: scan_done every PER_FAN cycles
    set_fan(0, 100, 50, 7, 1'b0);
    run_round(4'b0001, 2);
    if (done_t.size() >= 2)
      chk("scan_done_period", 64'((done_t[done_t.size()-1] - done_t[done_t.size()-2]) / 10),
          64'(PER_FAN));
    else chk("scan_done_count", 64'(done_t.size()), 64'd2);

    // four fans, 300/600/150/30
    set_fan(1, 50, 25, 3, 1'b0);
    set_fan(2, 200, 100, 0, 1'b0);
    set_fan(3, 1000, 500, 123, 1'b0);
    run_round(4'b1111, 4);

    // stalled fan 2; second round clears in the STORE cycle, set must win
    set_fan(2, 0, 0, 0, 1'b0);
    run_round(4'b0100, 1);
    fan_mask = 4'b0100;
    q.push_back('{2, 0, 1'b1});
    tgt = pops + 1;
    enable = 1'b1;
    @(posedge clk);
    repeat (PER_FAN - 1) @(posedge clk);
    @(negedge clk) stall_clr = 4'b0100;
    @(negedge clk) stall_clr = 4'b0000;
    enable = 1'b0;
    c = 0;
    while (pops < tgt && c < 20) begin @(negedge clk); c++; end
    chk("store_timing", 64'(pops), 64'(tgt));
    repeat (3) @(negedge clk);
    chk("stall_set_wins", 64'(stall[2]), 64'd1);
    @(negedge clk) stall_clr = 4'b0100;
    m_stall[2] = 1'b0;
    @(negedge clk) stall_clr = 4'b0000;
    chk("stall_clr", 64'(stall), 64'(m_stall));

    // 500 pulses: 15000 at scale 30, saturates at scale 200
    set_fan(1, 2, 1, 0, 1'b0);
    run_round(4'b0010, 1);

    // abort mid-MEASURE on fan 1, then resume on fan 1
    set_fan(0, 100, 30, 11, 1'b0);
    set_fan(2, 40, 10, 5, 1'b1);
    run_round(4'b1111, 3);
    fan_mask = 4'b1111;
    enable = 1'b1;
    repeat (500) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_no_valid", 64'(rpm_valid), 64'd0);
    repeat (3) @(negedge clk);
    run_round(4'b1111, 1);

    // randomized rounds
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 7) == 0) set_fan(i, 0, 0, 0, 1'($urandom_range(0, 1)));
        else begin
          int p;
          p = divs[$urandom_range(0, 11)];
          set_fan(i, p, $urandom_range(1, p - 1), $urandom_range(0, p - 1), 1'b0);
        end
      end
      run_round(4'($urandom_range(1, 15)), $urandom_range(1, 4));
      clr = 4'($urandom_range(0, 15));
      @(negedge clk) stall_clr = clr;
      m_stall = m_stall & ~clr;
      @(negedge clk) stall_clr = 4'b0000;
      chk("rand_stall_clr", 64'(stall), 64'(m_stall));
    end

    // async reset in the middle of a measurement
    fan_mask = 4'b1111;
    enable = 1'b1;
    repeat (300) @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("midrst_rpm_all",   rpm_all,        64'd0);
    chk("midrst_rpm_valid", 64'(rpm_valid), 64'd0);
    chk("midrst_stall",     64'(stall),     64'd0);
    chk("midrst_scan_done", 64'(scan_done), 64'd0);
    chk("midrst_busy",      64'(busy),      64'd0);
    enable = 1'b0;
    for (int i = 0; i < N; i++) begin m_rpm[i] = 0; m_rpm2[i] = 0; end
    m_stall = '0;
    mlast = N - 1;
    q.delete();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    set_fan(1, 20, 7, 2, 1'b0);
    set_fan(3, 250, 100, 9, 1'b0);
    @(negedge clk);
    run_round(4'b1010, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fan_tach_scheduler.md
# fan_tach_scheduler

Time-multiplexes a single tachometer measurement datapath across up to N_FANS fan TACH inputs. The block scans enabled fans round-robin, counts falling edges over a fixed window per fan, scales the count to RPM and publishes a per-fan result register and a sticky stall flag. It sits between the board TACH pins and the fan PWM control / register file in the fan subsystem.

## Interface
- N_FANS, 4: number of TACH inputs, 1..8.
- WINDOW_CYCLES, 50_000_000: measurement window per fan, in clk cycles.
- SETTLE_CYCLES, 1024: blanking cycles after switching channel, ≥3.
- RPM_SCALE, 30: RPM per counted pulse, equal to 60·f_clk/(WINDOW_CYCLES·pulses_per_rev).
- clk  in  1  system clock.
- rstn  in  1  asynchronous, active-low reset.
- tach  in  N_FANS  raw asynchronous TACH inputs.
- enable  in  1  scan enable, level.
- fan_mask  in  N_FANS  1 = fan included in scan; sampled at each channel selection.
- stall_clr  in  N_FANS  per-fan single-cycle clear of stall flag.
- rpm_all  out  16·N_FANS  packed RPM results; fan i at [16i+15:16i].
- rpm_valid  out  N_FANS  single-cycle pulse when fan i result updates.
- stall  out  N_FANS  sticky: fan i measured zero pulses in a full window.
- scan_done  out  1  single-cycle pulse after the last enabled fan of a round is stored.
- busy  out  1  high in every state except IDLE.

## Operation
- All tach bits pass through a 2-FF synchronizer continuously (independent of channel).
- FSM states: IDLE, SELECT, SETTLE, MEASURE, STORE.
- IDLE: if enable=1 and fan_mask≠0 → SELECT; otherwise stay.
- SELECT (1 cycle): choose next set bit of fan_mask strictly after the previous channel (wrapping; after reset, search starts at fan 0); clear pulse and window counters → SETTLE.
- SETTLE: SETTLE_CYCLES cycles, edges ignored; last cycle loads edge-history register with selected synchronized tach → MEASURE.
- MEASURE: WINDOW_CYCLES cycles; each falling edge (prev=1, cur=0) increments a 16-bit pulse counter, saturating at 0xFFFF → STORE.
- STORE (1 cycle): rpm = pulses·RPM_SCALE computed 32-bit, saturated to 0xFFFF, written to fan slot; rpm_valid[i] pulses; if pulses=0 set stall[i]. If the just-stored fan is the highest set bit in fan_mask, pulse scan_done. Then SELECT if enable=1 and fan_mask≠0, else IDLE.
- enable deasserted in SELECT/SETTLE/MEASURE: abort at the next cycle → IDLE, no result, no flags change; next round resumes at the aborted channel.
- fan_mask change mid-measurement: ignored until next SELECT.
- stall_clr[i] and stall set for same fan same cycle: set wins.
- Masked fans keep their last rpm and stall values.

## Timing
- Reset: rpm_all=0, rpm_valid=0, stall=0, scan_done=0, busy=0, FSM=IDLE, last channel=N_FANS−1.
- Per fan: 1 + SETTLE_CYCLES + WINDOW_CYCLES + 1 cycles from SELECT entry to STORE exit.
- rpm_all and rpm_valid updated on the same clock edge (end of STORE); output is registered.
- Tach-pin-to-counter latency: 3 cycles (2 sync + edge register).
- busy rises the cycle after enable is seen in IDLE.

## Structure
- Shared package fan_pkg: FSM state enum, default constants (CLK_HZ, RPM_SCALE, window), packed-slot width 16.
- Sub-module fan_tach_sync: N-bit 2-FF synchronizer, reused by other fan blocks.
- Counters, mux, scaler and FSM live in the top module.

## Test plan
Run with WINDOW_CYCLES=1000, SETTLE_CYCLES=16, RPM_SCALE=30, N_FANS=4.
- Fan 0 tach period 100 cycles, mask=0001, enable → rpm_all[15:0]=300, rpm_valid[0] pulse, scan_done pulse every 1018 cycles.
- Fans 0..3 periods 100/50/200/1000, mask=1111 → results 300/600/150/30 stored in order 0,1,2,3; one scan_done per round.
- Fan 2 held low, mask=0100 → rpm=0, stall[2]=1; stall_clr[2] pulse in STORE cycle keeps stall=1; pulse later clears it.
- Fan 1 period 2 cycles with RPM_SCALE=30 → 500 pulses ·30=15000; with RPM_SCALE=200 → saturated 0xFFFF.
- enable dropped mid-MEASURE on fan 1 → IDLE next cycle, no rpm_valid; re-enable restarts at fan 1.
- rstn asserted mid-MEASURE → all outputs 0 immediately; mask=1010 after release → scan starts at fan 1, then fan 3.
